ft600_fifo_responder: RTL and testbench

- Synthesizable model of the FT600 chip side of the 245-style synchronous FIFO bus.
- Presents host→FPGA words on RXF_n/OE_n/RD_n and accepts FPGA→host words on TXE_n/WR_n/BE.
- Used in self-test builds and benches to drive our FT600 FIFO master (command decode, loopback, ADC readout) without silicon.
- Host-side stream ports inject commands and drain returned data.

---
 rtl/ft600_fifo_responder_if.sv | 27 ++
 rtl/ft600_fifo_responder.sv | 128 ++++++++++++
 tb/tb_ft600_fifo_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ft600_fifo_responder_if.sv
// FT600 245-style synchronous FIFO bus as seen between the FPGA master and
// the chip-side responder. The responder's data drive is split into value and
// enable; whoever owns the pad builds the tristate.
interface ft600_fifo_responder_if #(
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
);
    logic              rxf_n;
    logic              txe_n;
    logic              oe_n;
    logic              rd_n;
    logic              wr_n;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] master_data;
    logic [DATA_W-1:0] resp_data;
    logic              resp_oe;

    modport master (
        input  rxf_n, txe_n, resp_data, resp_oe,
        output oe_n, rd_n, wr_n, be, master_data
    );

    modport slave (
        output rxf_n, txe_n, resp_data, resp_oe,
        input  oe_n, rd_n, wr_n, be, master_data
    );
endinterface

// File: rtl/ft600_fifo_responder.sv
// Chip-side model of the FT600 synchronous FIFO interface. Host command words
// queue in the h2f FIFO and are read out by the master over RXF_n/OE_n/RD_n;
// words the master writes over TXE_n/WR_n land in the f2h FIFO for the host
// side to drain. Protocol violations raise sticky flags and are dropped.
module ft600_fifo_responder #(
    parameter int H2F_DEPTH = 16,
    parameter int F2H_DEPTH = 16,
    parameter int DATA_W    = 16,
    parameter int BE_W      = 2
) (
    input  logic                         ft_clk,
    input  logic                         rst,
    ft600_fifo_responder_if.slave        ft,
    input  logic                         cmd_valid,
    input  logic [DATA_W-1:0]            cmd_data,
    output logic                         cmd_ready,
    input  logic                         txe_hold,
    output logic                         f2h_valid,
    output logic [DATA_W-1:0]            f2h_data,
    output logic [BE_W-1:0]              f2h_be,
    input  logic                         f2h_ready,
    output logic [$clog2(H2F_DEPTH):0]   h2f_level,
    output logic [$clog2(F2H_DEPTH):0]   f2h_level,
    output logic                         err_underflow,
    output logic                         err_overflow,
    output logic                         err_conflict
);
    localparam int HAW = $clog2(H2F_DEPTH);
    localparam int FAW = $clog2(F2H_DEPTH);
    localparam int HPW = HAW + 1;
    localparam int FPW = FAW + 1;
    localparam int FW  = DATA_W + BE_W;

    logic [DATA_W-1:0] h2f_mem [H2F_DEPTH];
    logic [FW-1:0]     f2h_mem [F2H_DEPTH];

    logic [HPW-1:0] h2f_wr_ptr, h2f_rd_ptr, h2f_wr_nxt, h2f_rd_nxt, h2f_lvl_nxt, h2f_level_q;
    logic [FPW-1:0] f2h_wr_ptr, f2h_rd_ptr, f2h_wr_nxt, f2h_rd_nxt, f2h_lvl_nxt, f2h_level_q;

    logic rxf_n_q, txe_n_q, post_rst_q;
    logic err_underflow_q, err_overflow_q, err_conflict_q;

    logic h2f_empty, h2f_full, f2h_empty, f2h_full;
    logic push_h, pop_h, push_f, pop_f;
    logic rd_req, wr_req;

    // Pointer-derived status and the per-edge transfer qualifiers.
    always_comb begin
        h2f_empty = (h2f_wr_ptr == h2f_rd_ptr);
        h2f_full  = (h2f_wr_ptr[HAW] != h2f_rd_ptr[HAW]) &&
                    (h2f_wr_ptr[HAW-1:0] == h2f_rd_ptr[HAW-1:0]);
        f2h_empty = (f2h_wr_ptr == f2h_rd_ptr);
        f2h_full  = (f2h_wr_ptr[FAW] != f2h_rd_ptr[FAW]) &&
                    (f2h_wr_ptr[FAW-1:0] == f2h_rd_ptr[FAW-1:0]);

        rd_req = ~ft.oe_n & ~ft.rd_n;
        wr_req = ~ft.wr_n;

        push_h = cmd_valid & ~h2f_full;
        // Pop is gated by the registered RXF_n the master actually sees.
        pop_h  = rd_req & ~rxf_n_q & ~h2f_empty;
        // A write while OE_n is low is a bus conflict and never stored.
        push_f = wr_req & ft.oe_n & ~txe_n_q & ~f2h_full;
        pop_f  = f2h_ready & ~f2h_empty;

        h2f_wr_nxt  = h2f_wr_ptr + HPW'(push_h);
        h2f_rd_nxt  = h2f_rd_ptr + HPW'(pop_h);
        f2h_wr_nxt  = f2h_wr_ptr + FPW'(push_f);
        f2h_rd_nxt  = f2h_rd_ptr + FPW'(pop_f);
        // Pointers wrap modulo 2*DEPTH, so the plain difference is the occupancy.
        h2f_lvl_nxt = h2f_wr_nxt - h2f_rd_nxt;
        f2h_lvl_nxt = f2h_wr_nxt - f2h_rd_nxt;
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge ft_clk) begin
        if (push_h) h2f_mem[h2f_wr_ptr[HAW-1:0]] <= cmd_data;
        if (push_f) f2h_mem[f2h_wr_ptr[FAW-1:0]] <= {ft.be, ft.master_data};
    end

    // Pointers, levels, bus flags and sticky error flags.
    always_ff @(posedge ft_clk) begin
        if (rst) begin
            h2f_wr_ptr      <= '0;
            h2f_rd_ptr      <= '0;
            f2h_wr_ptr      <= '0;
            f2h_rd_ptr      <= '0;
            h2f_level_q     <= '0;
            f2h_level_q     <= '0;
            rxf_n_q         <= 1'b1;
            txe_n_q         <= 1'b1;
            post_rst_q      <= 1'b1;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_conflict_q  <= 1'b0;
        end else begin
            h2f_wr_ptr  <= h2f_wr_nxt;
            h2f_rd_ptr  <= h2f_rd_nxt;
            f2h_wr_ptr  <= f2h_wr_nxt;
            f2h_rd_ptr  <= f2h_rd_nxt;
            h2f_level_q <= h2f_lvl_nxt;
            f2h_level_q <= f2h_lvl_nxt;
            post_rst_q  <= 1'b0;
            // Both flags stay deasserted through the first edge after reset.
            rxf_n_q     <= post_rst_q | (h2f_lvl_nxt == '0);
            txe_n_q     <= post_rst_q | (f2h_lvl_nxt == FPW'(F2H_DEPTH)) | txe_hold;
            if (rd_req & rxf_n_q)   err_underflow_q <= 1'b1;
            if (wr_req & txe_n_q)   err_overflow_q  <= 1'b1;
            if (wr_req & ~ft.oe_n)  err_conflict_q  <= 1'b1;
        end
    end

    // Bus-side and host-side outputs; both FIFOs are first-word-fall-through.
    always_comb begin
        ft.rxf_n      = rxf_n_q;
        ft.txe_n      = txe_n_q;
        ft.resp_oe    = ~ft.oe_n;
        ft.resp_data  = h2f_empty ? '0 : h2f_mem[h2f_rd_ptr[HAW-1:0]];
        cmd_ready     = ~h2f_full;
        f2h_valid     = ~f2h_empty;
        {f2h_be, f2h_data} = f2h_mem[f2h_rd_ptr[FAW-1:0]];
        h2f_level     = h2f_level_q;
        f2h_level     = f2h_level_q;
        err_underflow = err_underflow_q;
        err_overflow  = err_overflow_q;
        err_conflict  = err_conflict_q;
    end
endmodule

// File: tb/tb_ft600_fifo_responder.sv
// Self-checking bench for ft600_fifo_responder: scoreboard queues hold the
// words each FIFO should return, popped as the DUT presents them.
module tb_ft600_fifo_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_valid, cmd_ready, txe_hold, f2h_valid, f2h_ready;
    logic        err_underflow, err_overflow, err_conflict;
    logic [15:0] cmd_data, f2h_data;
    logic [1:0]  f2h_be;
    logic [4:0]  h2f_level, f2h_level;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] h2f_q [$];
    logic [17:0] f2h_q [$];

    ft600_fifo_responder_if #(.DATA_W(16), .BE_W(2)) bus ();

    ft600_fifo_responder #(
        .H2F_DEPTH(16), .F2H_DEPTH(16), .DATA_W(16), .BE_W(2)
    ) dut (
        .ft_clk        (clk),
        .rst           (rst),
        .ft            (bus),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .txe_hold      (txe_hold),
        .f2h_valid     (f2h_valid),
        .f2h_data      (f2h_data),
        .f2h_be        (f2h_be),
        .f2h_ready     (f2h_ready),
        .h2f_level     (h2f_level),
        .f2h_level     (f2h_level),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_conflict  (err_conflict)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_f2h(input string tag);
        int budget;
        logic [17:0] e;
        budget    = 200;
        f2h_ready = 1'b1;
        while (f2h_q.size() > 0 && budget > 0) begin
            if (f2h_valid) begin
                e = f2h_q.pop_front();
                check(tag, {14'd0, f2h_be, f2h_data}, {14'd0, e});
            end
            tick();
            budget--;
        end
        f2h_ready = 1'b0;
        check({tag, "_left"}, f2h_q.size(), 0);
        f2h_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; txe_hold = 1'b0; f2h_ready = 1'b0;
        bus.oe_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.be = '0; bus.master_data = '0;

        // reset
        tick(); tick();
        check("rst_rxf", bus.rxf_n, 1);
        check("rst_txe", bus.txe_n, 1);
        check("rst_h2f_lvl", h2f_level, 0);
        check("rst_f2h_lvl", f2h_level, 0);
        check("rst_errs", {err_underflow, err_overflow, err_conflict}, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        tick();
        check("post_rst_rxf", bus.rxf_n, 1);
        check("post_rst_txe", bus.txe_n, 1);
        tick();
        check("idle_txe", bus.txe_n, 0);
        check("idle_rxf", bus.rxf_n, 1);

        // loopback
        cmd_valid = 1'b1; cmd_data = 16'h7ABC; h2f_q.push_back(16'h7ABC);
        tick();
        cmd_valid = 1'b0;
        check("lb_rxf", bus.rxf_n, 0);
        check("lb_h2f_lvl", h2f_level, 1);
        bus.oe_n = 1'b0;
        #1;
        check("lb_oe", bus.resp_oe, 1);
        check("lb_data", bus.resp_data, h2f_q[0]);
        tick();
        check("lb_lvl_hold", h2f_level, 1);
        bus.rd_n = 1'b0;
        void'(h2f_q.pop_front());
        tick();
        bus.rd_n = 1'b1; bus.oe_n = 1'b1;
        check("lb_lvl_pop", h2f_level, 0);
        check("lb_rxf_pop", bus.rxf_n, 1);
        bus.wr_n = 1'b0; bus.be = 2'b11; bus.master_data = 16'h7ABC;
        f2h_q.push_back({2'b11, 16'h7ABC});
        tick();
        bus.wr_n = 1'b1;
        check("lb_f2h_valid", f2h_valid, 1);
        check("lb_f2h_data", f2h_data, 16'h7ABC);
        check("lb_f2h_be", f2h_be, 2'b11);
        drain_f2h("lb_drain");

        // h2f full
        for (int i = 0; i < 16; i++) begin
            cmd_valid = 1'b1; cmd_data = 16'h1000 + 16'(i);
            h2f_q.push_back(cmd_data);
            tick();
        end
        cmd_data = 16'hDEAD;
        check("h2f_full_ready", cmd_ready, 0);
        check("h2f_full_lvl", h2f_level, 16);
        tick();
        cmd_valid = 1'b0;
        check("h2f_17th_lvl", h2f_level, 16);
        bus.oe_n = 1'b0; bus.rd_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            check("h2f_pop", bus.resp_data, h2f_q.pop_front());
            tick();
        end
        bus.oe_n = 1'b1; bus.rd_n = 1'b1;
        check("h2f_empty_rxf", bus.rxf_n, 1);
        check("h2f_empty_lvl", h2f_level, 0);
        check("h2f_no_uflow", err_underflow, 0);

        // underflow
        bus.oe_n = 1'b0; bus.rd_n = 1'b0;
        #1;
        check("uflow_data", bus.resp_data, 0);
        tick();
        bus.oe_n = 1'b1; bus.rd_n = 1'b1;
        check("uflow_flag", err_underflow, 1);
        check("uflow_lvl", h2f_level, 0);

        // f2h full and overflow
        for (int i = 0; i < 16; i++) begin
            bus.wr_n = 1'b0; bus.be = 2'(i); bus.master_data = 16'h2000 + 16'(i);
            f2h_q.push_back({bus.be, bus.master_data});
            tick();
        end
        check("f2h_full_txe", bus.txe_n, 1);
        check("f2h_full_lvl", f2h_level, 16);
        check("f2h_no_oflow", err_overflow, 0);
        bus.master_data = 16'hDEAD;
        tick();
        bus.wr_n = 1'b1;
        check("oflow_flag", err_overflow, 1);
        check("oflow_lvl", f2h_level, 16);
        drain_f2h("f2h_full_drain");

        // conflict
        bus.oe_n = 1'b0; bus.wr_n = 1'b0; bus.master_data = 16'hBEEF;
        tick();
        bus.oe_n = 1'b1; bus.wr_n = 1'b1;
        check("conflict_flag", err_conflict, 1);
        check("conflict_lvl", f2h_level, 0);
        check("conflict_valid", f2h_valid, 0);
        check("oflow_sticky", err_overflow, 1);

        // simultaneous push/pop on f2h
        bus.wr_n = 1'b0; bus.be = 2'b01; bus.master_data = 16'h3000;
        f2h_q.push_back({2'b01, 16'h3000});
        tick();
        check("simul_lvl0", f2h_level, 1);
        f2h_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.be = 2'(i); bus.master_data = 16'h3000 + 16'(i);
            f2h_q.push_back({bus.be, bus.master_data});
            check("simul_head", {14'd0, f2h_be, f2h_data}, {14'd0, f2h_q.pop_front()});
            tick();
            check("simul_lvl", f2h_level, 1);
        end
        bus.wr_n = 1'b1;
        f2h_ready = 1'b0;
        drain_f2h("simul_drain");

        // TXE hold
        txe_hold = 1'b1;
        tick();
        check("hold_txe", bus.txe_n, 1);
        txe_hold = 1'b0;
        tick();
        check("release_txe", bus.txe_n, 0);

        // reset mid-burst
        for (int i = 0; i < 5; i++) begin
            bus.wr_n = 1'b0; bus.be = 2'b10; bus.master_data = 16'h4000 + 16'(i);
            cmd_valid = 1'b1; cmd_data = 16'h5000 + 16'(i);
            tick();
        end
        check("burst_lvl", f2h_level, 5);
        bus.master_data = 16'h4005;
        rst = 1'b1;
        tick();
        check("mid_rst_h2f_lvl", h2f_level, 0);
        check("mid_rst_f2h_lvl", f2h_level, 0);
        check("mid_rst_rxf", bus.rxf_n, 1);
        check("mid_rst_txe", bus.txe_n, 1);
        check("mid_rst_errs", {err_underflow, err_overflow, err_conflict}, 0);
        check("mid_rst_valid", f2h_valid, 0);
        check("mid_rst_data", bus.resp_data, 0);
        rst = 1'b0; bus.wr_n = 1'b1; cmd_valid = 1'b0;
        f2h_q.delete(); h2f_q.delete();
        tick();
        check("mid_post_rxf", bus.rxf_n, 1);
        check("mid_post_txe", bus.txe_n, 1);
        tick();
        check("mid_txe_open", bus.txe_n, 0);
        for (int i = 5; i < 10; i++) begin
            bus.wr_n = 1'b0; bus.be = 2'b10; bus.master_data = 16'h4000 + 16'(i);
            f2h_q.push_back({bus.be, bus.master_data});
            tick();
        end
        bus.wr_n = 1'b1;
        drain_f2h("mid_drain");
        check("mid_end_valid", f2h_valid, 0);
        check("mid_end_lvl", f2h_level, 0);
        check("mid_end_errs", {err_underflow, err_overflow, err_conflict}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
